vga_pcap: RTL

Pixel-capture receiver for the VGA/LCD subsystem. It is the receive-side counterpart of the pixel generator. It samples a parallel RGB/HSYNC/VSYNC/BLANK video stream at pixel rate and aligns to frame boundaries. Active pixels are pushed as 24-bit words into a capture FIFO write port with end-of-line and end-of-frame markers, and the measured resolution is reported. It is used for loopback self-test of the display path and for external video input.

---
 rtl/vga_pcap_if.sv | 19 +
 rtl/vga_pcap.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pcap_if.sv
// Capture FIFO write port: pixel word, strobe, line/frame markers
// and the FIFO full back-pressure flag.
interface vga_pcap_if;
  logic [23:0] cap_q;
  logic        cap_wreq;
  logic        cap_full;
  logic        eol;
  logic        eof;

  modport master (
    output cap_q, cap_wreq, eol, eof,
    input  cap_full
  );

  modport slave (
    input  cap_q, cap_wreq, eol, eof,
    output cap_full
  );
endinterface

// File: rtl/vga_pcap.sv
// Pixel-capture receiver: aligns to vsync, pushes active pixels to a FIFO.
// Optional resolution check: define VGA_PCAP_RES_CHK_EN.
module vga_pcap #(
  parameter int HCW = 12,
  parameter int VCW = 11
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           pclk_ena,
  input  logic           ctrl_ven,
  input  logic           ctrl_HSyncL,
  input  logic           ctrl_VSyncL,
  input  logic           ctrl_BlankL,
  input  logic           ctrl_ovf_clr,
  input  logic           hsync_i,
  input  logic           vsync_i,
  input  logic           blank_i,
  input  logic [7:0]     r_i,
  input  logic [7:0]     g_i,
  input  logic [7:0]     b_i,
  vga_pcap_if.master     cap,
  output logic [HCW-1:0] hres_o,
  output logic [VCW-1:0] vres_o,
  output logic           stat_sync,
  output logic           stat_ovf,
  input  logic [HCW-1:0] ctrl_hres,
  input  logic [VCW-1:0] ctrl_vres,
  output logic           stat_rerr
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    ACTIVE
  } state_e;

  state_e state_q, state_d;

  logic        s1_new_q;
  logic        s1_vs_q;
  logic        s1_bl_q;
  logic [23:0] s1_rgb_q;

  logic pvs_q, pvs_d;
  logic pbl_q, pbl_d;

  logic [HCW-1:0] pix_q, pix_d;
  logic [VCW-1:0] line_q, line_d;
  logic [HCW-1:0] hres_q, hres_d;
  logic [VCW-1:0] vres_q, vres_d;
  logic [23:0]    capq_q, capq_d;
  logic wreq_q, wreq_d;
  logic eol_q, eol_d;
  logic eof_q, eof_d;
  logic ovf_q, ovf_d;
  logic rerr_q, rerr_d;

  logic vs, bl;
  logic vs_fall, vs_rise, line_end;
  logic run;
  logic [HCW-1:0] pix_inc;
  logic [VCW-1:0] line_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_new_q <= 1'b0;
      s1_vs_q  <= 1'b0;
      s1_bl_q  <= 1'b0;
      s1_rgb_q <= '0;
    end else begin
      s1_new_q <= pclk_ena;
      if (pclk_ena) begin
        s1_vs_q  <= vsync_i;
        s1_bl_q  <= blank_i;
        s1_rgb_q <= {r_i, g_i, b_i};
      end
    end
  end

  assign vs = s1_vs_q ^ ctrl_VSyncL;
  assign bl = s1_bl_q ^ ctrl_BlankL;

  assign vs_fall  = s1_new_q & pvs_q & ~vs;
  assign vs_rise  = s1_new_q & ~pvs_q & vs;
  assign line_end = s1_new_q & ~pbl_q & bl;
  assign run      = (state_q == ACTIVE) & ctrl_ven;

  assign pix_inc  = (pix_q == '1) ? pix_q : pix_q + 1'b1;
  assign line_inc = (line_q == '1) ? line_q : line_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pvs_d   = pvs_q;
    pbl_d   = pbl_q;
    pix_d   = pix_q;
    line_d  = line_q;
    hres_d  = hres_q;
    vres_d  = vres_q;
    capq_d  = capq_q;
    wreq_d  = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;
    ovf_d   = ovf_q;
    rerr_d  = rerr_q;

    if (s1_new_q) begin
      pvs_d = vs;
      pbl_d = bl;
    end

    unique case (state_q)
      IDLE:    if (ctrl_ven) state_d = WAIT_VS;
      WAIT_VS: if (vs_fall) state_d = ACTIVE;
      ACTIVE:  state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
    if (!ctrl_ven) state_d = IDLE;

    if (ctrl_ovf_clr) begin
      ovf_d  = 1'b0;
      rerr_d = 1'b0;
    end

    if (!run) begin
      pix_d  = '0;
      line_d = '0;
    end else if (s1_new_q) begin
      if (!bl) begin
        pix_d = pix_inc;
        if (!cap.cap_full) begin
          capq_d = s1_rgb_q;
          wreq_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (line_end) begin
        eol_d  = 1'b1;
        hres_d = pix_q;
        pix_d  = '0;
        line_d = line_inc;
      end
      // A blank edge on the vsync sample closes the last line too
      if (vs_rise) begin
        eof_d  = 1'b1;
        vres_d = line_end ? line_inc : line_q;
        line_d = '0;
        pix_d  = '0;
      end
`ifdef VGA_PCAP_RES_CHK_EN
      if (eol_d && (hres_d != ctrl_hres)) rerr_d = 1'b1;
      if (eof_d && (vres_d != ctrl_vres)) rerr_d = 1'b1;
`endif
    end

`ifndef VGA_PCAP_RES_CHK_EN
    rerr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pvs_q   <= 1'b0;
      pbl_q   <= 1'b1;
      pix_q   <= '0;
      line_q  <= '0;
      hres_q  <= '0;
      vres_q  <= '0;
      capq_q  <= '0;
      wreq_q  <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pvs_q   <= pvs_d;
      pbl_q   <= pbl_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      hres_q  <= hres_d;
      vres_q  <= vres_d;
      capq_q  <= capq_d;
      wreq_q  <= wreq_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      ovf_q   <= ovf_d;
      rerr_q  <= rerr_d;
    end
  end

  assign cap.cap_q    = capq_q;
  assign cap.cap_wreq = wreq_q;
  assign cap.eol      = eol_q;
  assign cap.eof      = eof_q;
  assign hres_o       = hres_q;
  assign vres_o       = vres_q;
  assign stat_sync    = (state_q == ACTIVE);
  assign stat_ovf     = ovf_q;
  assign stat_rerr    = rerr_q;

`ifdef VGA_PCAP_RES_CHK_EN
  logic unused_pins;
  assign unused_pins = hsync_i ^ ctrl_HSyncL;
`else
  logic unused_pins;
  assign unused_pins = ^{hsync_i, ctrl_HSyncL,
                         ctrl_hres, ctrl_vres};
`endif

endmodule
